// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces whole-scan results
// and presents the accepted key as a 4-bit code with a one-cycle strobe.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] decode,
    output logic       key_down,
    output logic       key_pulse
);
    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);
    localparam logic [3:0] KMAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    logic [3:0]    sync1, row_s, hits, col_code, scan_code, acc_code;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx, hit_cnt, first_row;
    logic [2:0]    col_hits, hit_sum;
    logic [4:0]    res, prev_res;
    logic [CW-1:0] stable_cnt, cnt_next;
    logic          sample, eos, accept;

    // A scan result is {valid, code}; NONE and MULTI both collapse to zero.
    always_comb begin
        sample    = dwell == LAST;
        eos       = sample && col_idx == 2'd3;
        hits      = ~row_s;
        col_hits  = {2'b0, hits[0]} + {2'b0, hits[1]} + {2'b0, hits[2]} + {2'b0, hits[3]};
        first_row = hits[0] ? 2'd0 : hits[1] ? 2'd1 : hits[2] ? 2'd2 : 2'd3;
        col_code  = KMAP[{col_idx, first_row}];
        hit_sum   = {1'b0, hit_cnt} + col_hits;
        scan_code = hit_cnt == 2'd0 ? col_code : acc_code;
        res       = hit_sum == 3'd1 ? {1'b1, scan_code} : 5'b0;
        cnt_next  = res != prev_res ? CW'(1) : stable_cnt == CMAX ? CMAX : stable_cnt + CW'(1);
        accept    = eos && cnt_next == CMAX && res != {key_down, decode};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 4'hF;
            row_s      <= 4'hF;
            dwell      <= '0;
            col_idx    <= 2'd0;
            col        <= 4'b1110;
            hit_cnt    <= 2'd0;
            acc_code   <= 4'h0;
            prev_res   <= 5'b0;
            stable_cnt <= '0;
            decode     <= 4'h0;
            key_down   <= 1'b0;
            key_pulse  <= 1'b0;
        end else begin
            sync1     <= row;
            row_s     <= sync1;
            dwell     <= sample ? '0 : dwell + DW'(1);
            key_pulse <= 1'b0;
            if (sample) begin
                col_idx  <= col_idx + 2'd1;
                col      <= {col[2:0], col[3]};
                hit_cnt  <= eos ? 2'd0 : hit_sum >= 3'd2 ? 2'd2 : hit_sum[1:0];
                acc_code <= eos ? 4'h0 : scan_code;
            end
            if (eos) begin
                stable_cnt <= cnt_next;
                prev_res   <= res;
            end
            if (accept) begin
                decode    <= res[3:0];
                key_down  <= res[4];
                key_pulse <= res[4];
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: table-driven scan sequences, reset corner cases and
// randomized key activity checked against a scan-level reference model.
module tb_keypad_scanner;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row, col, decode;
    logic        key_down, key_pulse;
    logic [15:0] held = 16'h0;
    int          total = 0, bad = 0;

    typedef struct {
        logic [15:0] mask;
        int          dec;
        int          down;
        int          pulses;
    } vec_t;
    vec_t tbl[$];
    int   res_hist[$];
    int   acc = -1;

    keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(D)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .decode(decode), .key_down(key_down), .key_pulse(key_pulse)
    );

    always #5 clk = ~clk;

    // Keypad model: held key (r,c) pulls row r low while column c is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (held[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] m, input int d, input int k, input int p);
        vec_t v;
        v.mask = m; v.dec = d; v.down = k; v.pulses = p;
        tbl.push_back(v);
    endtask

    function automatic int key_val(input int idx);
        int c = idx / 4, r = idx % 4;
        if (c == 3) return 10 + r;
        if (r < 3) return 3 * r + c + 1;
        return c == 0 ? 0 : c == 1 ? 15 : 14;
    endfunction

    task automatic model_scan(input logic [15:0] m, output int ed, output int ek, output int ep);
        int res = -1;
        bit eq = 1;
        if ($countones(m) == 1)
            for (int i = 0; i < 16; i++) if (m[i]) res = key_val(i);
        res_hist.push_back(res);
        ep = 0;
        if (res_hist.size() >= D) begin
            for (int i = res_hist.size() - D; i < res_hist.size(); i++)
                if (res_hist[i] != res) eq = 0;
            if (eq && res != acc) begin
                acc = res;
                ep = res != -1;
            end
        end
        ed = acc < 0 ? 0 : acc;
        ek = acc >= 0;
    endtask

    // Holds the mask for one full scan starting at a scan boundary.
    task automatic run_scan(input logic [15:0] m, input int ed, input int ek, input int ep, input string nm);
        int p = 0;
        held = m;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            p += int'(key_pulse);
        end
        chk({nm, ".decode"}, int'(decode), ed);
        chk({nm, ".key_down"}, int'(key_down), ek);
        chk({nm, ".pulses"}, p, ep);
        chk({nm, ".pulse_now"}, int'(key_pulse), ep);
    endtask

    initial begin
        int ed, ek, ep, len, p;
        logic [15:0] m;
        add(16'h0010, 0, 0, 0); add(16'h0010, 0, 0, 0); add(16'h0010, 2, 1, 1);
        add(16'h0000, 2, 1, 0); add(16'h0000, 2, 1, 0); add(16'h0000, 0, 0, 0);
        add(16'h1000, 0, 0, 0); add(16'h0000, 0, 0, 0); add(16'h1000, 0, 0, 0);
        add(16'h0000, 0, 0, 0); add(16'h1000, 0, 0, 0); add(16'h1000, 0, 0, 0);
        add(16'h1000, 10, 1, 1); add(16'h1000, 10, 1, 0);
        add(16'h0000, 10, 1, 0); add(16'h0000, 10, 1, 0); add(16'h0000, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(16'h0101, 0, 0, 0);
        add(16'h0001, 0, 0, 0); add(16'h0001, 0, 0, 0); add(16'h0001, 1, 1, 1);
        add(16'h2000, 1, 1, 0); add(16'h2000, 1, 1, 0); add(16'h2000, 11, 1, 1);
        add(16'h4000, 11, 1, 0); add(16'h4000, 11, 1, 0); add(16'h4000, 12, 1, 1);
        add(16'h0000, 12, 1, 0); add(16'h0000, 12, 1, 0); add(16'h0000, 0, 0, 0);

        repeat (3) @(posedge clk); #1;
        chk("rst.col", int'(col), 4'b1110);
        chk("rst.decode", int'(decode), 0);
        chk("rst.key_down", int'(key_down), 0);
        chk("rst.key_pulse", int'(key_pulse), 0);
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("col.dwell", int'(col), 4'b1110);
        @(posedge clk); #1;
        chk("col.first_adv", int'(col), 4'b1101);
        repeat (11) @(posedge clk); #1;
        chk("col.third", int'(col), 4'b0111);
        @(posedge clk); #1;
        chk("col.wrap", int'(col), 4'b1110);

        foreach (tbl[i])
            run_scan(tbl[i].mask, tbl[i].dec, tbl[i].down, tbl[i].pulses, $sformatf("vec%0d", i));

        run_scan(16'h0020, 0, 0, 0, "pre_rst1");
        run_scan(16'h0020, 0, 0, 0, "pre_rst2");
        p = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            p += int'(key_pulse);
        end
        chk("mid_rst.pulses", p, 0);
        chk("mid_rst.decode", int'(decode), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("mid_rst.col", int'(col), 4'b1110);
        rst = 1'b1;
        run_scan(16'h0020, 0, 0, 0, "post_rst1");
        run_scan(16'h0020, 0, 0, 0, "post_rst2");
        run_scan(16'h0020, 5, 1, 1, "post_rst3");

        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        res_hist.delete();
        acc = -1;
        for (int s = 0; s < 50; s++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: m = 16'h0;
                8, 9:    m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: m = 16'h1 << $urandom_range(0, 15);
            endcase
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                model_scan(m, ed, ek, ep);
                run_scan(m, ed, ek, ep, $sformatf("rnd%0d_%0d", s, j));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
